// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Arbitrates a single shared line-fill / write-back memory port between an
//   I-cache (read only) and a D-cache (read and write-back). Exactly one
//   transaction is outstanding at a time. A request seen in IDLE is granted on
//   the next rising edge, so the memory strobe follows the request by one
//   cycle. Completion (mem_ready) always returns the arbiter to IDLE for one
//   turnaround cycle before the next grant.
//
//   Optional feature macro: ARB_RR_EN
//     defined   -> round-robin on contention using a 1-bit last-served pointer
//     undefined -> fixed priority, the D-cache always wins contention
//
// Ports
//   clk, proc_reset               clock, synchronous active-high reset
//   i_mem_read/i_mem_addr         I-cache fill request (level) and address
//   i_mem_rdata/i_mem_ready       I-cache fill data and completion
//   d_mem_read/d_mem_write        D-cache fill / write-back requests (level)
//   d_mem_addr/d_mem_wdata        D-cache address and write-back line
//   d_mem_rdata/d_mem_ready       D-cache fill data and completion
//   mem_read/mem_write            shared memory strobes
//   mem_addr/mem_wdata            shared memory address and write line
//   mem_rdata/mem_ready           shared memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset,
    input  logic              i_mem_read,
    input  logic [ADDR_W-1:0] i_mem_addr,
    output logic [DATA_W-1:0] i_mem_rdata,
    output logic              i_mem_ready,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [ADDR_W-1:0] d_mem_addr,
    input  logic [DATA_W-1:0] d_mem_wdata,
    output logic [DATA_W-1:0] d_mem_rdata,
    output logic              d_mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   i_req, d_req;
    logic   tie_to_d;   // which port wins when both request in IDLE

    assign i_req = i_mem_read;
    assign d_req = d_mem_read | d_mem_write;

`ifdef ARB_RR_EN
    // last_d_q = 1 means the D-cache completed the most recent transaction.
    // Reset value 0 reads as "I last served", so the first tie goes to D.
    logic last_d_q, last_d_d;

    always_comb begin
        last_d_d = last_d_q;
        if (mem_ready && state_q == SERVE_I) last_d_d = 1'b0;
        if (mem_ready && state_q == SERVE_D) last_d_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (proc_reset) last_d_q <= 1'b0;
        else            last_d_q <= last_d_d;
    end

    assign tie_to_d = ~last_d_q;
`else
    assign tie_to_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (proc_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Next-state: grant is frozen while serving; leaving happens on
    // completion or when the granted requester withdraws.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (i_req && d_req) state_d = tie_to_d ? SERVE_D : SERVE_I;
                else if (d_req)     state_d = SERVE_D;
                else if (i_req)     state_d = SERVE_I;
            end
            SERVE_I: begin
                if (mem_ready || !i_req) state_d = IDLE;
            end
            SERVE_D: begin
                if (mem_ready || !d_req) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-side mux: pure pass-through of the granted port, zeros in IDLE.
    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            SERVE_I: begin
                mem_read = i_mem_read;
                mem_addr = i_mem_addr;
            end
            SERVE_D: begin
                mem_read  = d_mem_read;
                mem_write = d_mem_write;
                mem_addr  = d_mem_addr;
                mem_wdata = d_mem_wdata;
            end
            default: ;
        endcase
    end

    // Ready is masked while reset is asserted so a late memory response in
    // the reset cycle cannot leak to a cache.
    assign i_mem_ready = mem_ready & (state_q == SERVE_I) & ~proc_reset;
    assign d_mem_ready = mem_ready & (state_q == SERVE_D) & ~proc_reset;
    assign i_mem_rdata = mem_rdata;
    assign d_mem_rdata = mem_rdata;

endmodule
